// File: rtl/mvmul_engine.sv
// rtl/mvmul_engine.sv - runtime-sized matrix-vector multiply (y = A*x or y += A*x) over a shared 3R/1W RAM
module mvmul_engine #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DIM_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] x_base,
    input  logic [ADDR_WIDTH-1:0] y_base,
    input  logic                  accumulate,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_raddr_0,
    input  logic [WIDTH-1:0]      ram_rdata_0,
    output logic [ADDR_WIDTH-1:0] ram_raddr_1,
    input  logic [WIDTH-1:0]      ram_rdata_1,
    output logic [ADDR_WIDTH-1:0] ram_raddr_2,
    input  logic [WIDTH-1:0]      ram_rdata_2,
    output logic [ADDR_WIDTH-1:0] ram_waddr_0,
    output logic [WIDTH-1:0]      ram_wdata_0,
    output logic                  ram_wen_0
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [DIM_WIDTH-1:0] DIM_ONE  = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] DIM_ZERO = '0;

    state_t                state_q, state_d;
    logic [DIM_WIDTH-1:0]  rows_q, rows_d;
    logic [DIM_WIDTH-1:0]  cols_q, cols_d;
    logic [ADDR_WIDTH-1:0] x_base_q, x_base_d;
    logic [ADDR_WIDTH-1:0] y_base_q, y_base_d;
    logic                  acc_mode_q, acc_mode_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [DIM_WIDTH-1:0]  i_q, i_d;
    logic [DIM_WIDTH-1:0]  j_q, j_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            x_base_q   <= '0;
            y_base_q   <= '0;
            acc_mode_q <= 1'b0;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            row_base_q <= '0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            x_base_q   <= x_base_d;
            y_base_q   <= y_base_d;
            acc_mode_q <= acc_mode_d;
            acc_q      <= acc_d;
            i_q        <= i_d;
            j_q        <= j_d;
            row_base_q <= row_base_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        x_base_d    = x_base_q;
        y_base_d    = y_base_q;
        acc_mode_d  = acc_mode_q;
        acc_d       = acc_q;
        i_d         = i_q;
        j_d         = j_q;
        row_base_d  = row_base_q;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        ram_raddr_0 = '0;
        ram_raddr_1 = '0;
        ram_raddr_2 = '0;
        ram_waddr_0 = '0;
        ram_wdata_0 = '0;
        ram_wen_0   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d     = rows;
                    cols_d     = cols;
                    x_base_d   = x_base;
                    y_base_d   = y_base;
                    acc_mode_d = accumulate;
                    acc_d      = '0;
                    i_d        = '0;
                    j_d        = '0;
                    row_base_d = a_base;
                    if (rows == DIM_ZERO) begin
                        state_d = S_DONE;
                    end else if (cols == DIM_ZERO) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_MAC;
                    end
                end
            end

            S_MAC: begin
                ram_raddr_0 = row_base_q + ADDR_WIDTH'(j_q);
                ram_raddr_1 = x_base_q + ADDR_WIDTH'(j_q);
                acc_d       = acc_q + ram_rdata_0 * ram_rdata_1;
                if (j_q == cols_q - DIM_ONE) begin
                    state_d = S_WRITE;
                end else begin
                    j_d = j_q + DIM_ONE;
                end
            end

            S_WRITE: begin
                // Old y is read combinationally in the same cycle it is overwritten.
                ram_raddr_2 = y_base_q + ADDR_WIDTH'(i_q);
                ram_waddr_0 = y_base_q + ADDR_WIDTH'(i_q);
                ram_wen_0   = 1'b1;
                ram_wdata_0 = acc_mode_q ? (acc_q + ram_rdata_2) : acc_q;
                acc_d       = '0;
                j_d         = '0;
                row_base_d  = row_base_q + ADDR_WIDTH'(cols_q);
                i_d         = i_q + DIM_ONE;
                if (i_q == rows_q - DIM_ONE) begin
                    state_d = S_DONE;
                end else if (cols_q == DIM_ZERO) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_MAC;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mvmul_engine.sv
// tb/tb_mvmul_engine.sv - directed self-checking bench for mvmul_engine with a behavioural 3R/1W RAM
module tb_mvmul_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [4:0]  a_base;
    logic [4:0]  x_base;
    logic [4:0]  y_base;
    logic        accumulate;
    logic        busy;
    logic        done;
    logic [4:0]  ram_raddr_0;
    logic [31:0] ram_rdata_0;
    logic [4:0]  ram_raddr_1;
    logic [31:0] ram_rdata_1;
    logic [4:0]  ram_raddr_2;
    logic [31:0] ram_rdata_2;
    logic [4:0]  ram_waddr_0;
    logic [31:0] ram_wdata_0;
    logic        ram_wen_0;

    logic [31:0] mem [0:31];
    logic        tb_we;
    logic [4:0]  tb_waddr;
    logic [31:0] tb_wdata;
    int          wr_cnt = 0;
    logic [4:0]  wr_log [0:63];

    int checks = 0;
    int errors = 0;

    mvmul_engine #(
        .WIDTH      (32),
        .ADDR_WIDTH (5),
        .DIM_WIDTH  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rows        (rows),
        .cols        (cols),
        .a_base      (a_base),
        .x_base      (x_base),
        .y_base      (y_base),
        .accumulate  (accumulate),
        .busy        (busy),
        .done        (done),
        .ram_raddr_0 (ram_raddr_0),
        .ram_rdata_0 (ram_rdata_0),
        .ram_raddr_1 (ram_raddr_1),
        .ram_rdata_1 (ram_rdata_1),
        .ram_raddr_2 (ram_raddr_2),
        .ram_rdata_2 (ram_rdata_2),
        .ram_waddr_0 (ram_waddr_0),
        .ram_wdata_0 (ram_wdata_0),
        .ram_wen_0   (ram_wen_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata_0 = mem[ram_raddr_0];
    assign ram_rdata_1 = mem[ram_raddr_1];
    assign ram_rdata_2 = mem[ram_raddr_2];

    always @(posedge clk) begin
        if (ram_wen_0) begin
            mem[ram_waddr_0] <= ram_wdata_0;
            wr_log[wr_cnt % 64] <= ram_waddr_0;
            wr_cnt = wr_cnt + 1;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke_mem(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_waddr = addr;
        tb_wdata = data;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    // Launches one job and measures done latency in cycles after the accept edge.
    task automatic run_job(input logic [3:0] r, input logic [3:0] c, input logic [4:0] ab,
                           input logic [4:0] xb, input logic [4:0] yb, input logic acc,
                           input int exp_lat, input bit poke, input string tag,
                           output int nwr);
        int cyc;
        int busy_low;
        int w0;
        @(negedge clk);
        rows = r; cols = c; a_base = ab; x_base = xb; y_base = yb; accumulate = acc;
        start = 1'b1;
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_low = 0;
        while (!done && cyc < 200) begin
            if (!busy) busy_low++;
            if (poke && cyc == 3) begin
                start = 1'b1;
                rows  = 4'd0;
                cols  = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!busy) busy_low++;
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_busy_low_cycles"}, busy_low, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        nwr = wr_cnt - w0;
    endtask

    initial begin
        int nwr;
        int w0;
        rst = 1'b1; start = 1'b0; rows = '0; cols = '0;
        a_base = '0; x_base = '0; y_base = '0; accumulate = 1'b0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_wen", {31'd0, ram_wen_0}, 32'd0);
        check("reset_waddr", {27'd0, ram_waddr_0}, 32'd0);
        check("reset_wdata", ram_wdata_0, 32'd0);
        check("reset_raddr0", {27'd0, ram_raddr_0}, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 32; k++) poke_mem(k[4:0], 32'd0);
        poke_mem(5'd0, 32'd6); poke_mem(5'd1, 32'd1); poke_mem(5'd2, 32'd2);
        poke_mem(5'd3, 32'd3); poke_mem(5'd4, 32'd7); poke_mem(5'd5, 32'd5);
        poke_mem(5'd6, 32'd5); poke_mem(5'd7, 32'd2); poke_mem(5'd8, 32'd9);
        poke_mem(5'd9, 32'd9); poke_mem(5'd10, 32'd3); poke_mem(5'd11, 32'd7);

        run_job(4'd3, 4'd3, 5'd0, 5'd9, 5'd12, 1'b0, 13, 1'b0, "job1", nwr);
        check("job1_y0", mem[12], 32'd71);
        check("job1_y1", mem[13], 32'd83);
        check("job1_y2", mem[14], 32'd114);
        check("job1_writes", nwr, 3);

        // A start pulse mid-job (with rows=0) must be ignored.
        run_job(4'd3, 4'd3, 5'd0, 5'd9, 5'd12, 1'b1, 13, 1'b1, "job2_acc", nwr);
        check("job2_y0", mem[12], 32'd142);
        check("job2_y1", mem[13], 32'd166);
        check("job2_y2", mem[14], 32'd228);
        check("job2_writes", nwr, 3);

        run_job(4'd0, 4'd3, 5'd0, 5'd9, 5'd12, 1'b0, 1, 1'b0, "rows0", nwr);
        check("rows0_writes", nwr, 0);
        check("rows0_y0_kept", mem[12], 32'd142);

        poke_mem(5'd20, 32'd55);
        poke_mem(5'd21, 32'd66);
        run_job(4'd2, 4'd0, 5'd0, 5'd9, 5'd20, 1'b0, 3, 1'b0, "cols0", nwr);
        check("cols0_y0", mem[20], 32'd0);
        check("cols0_y1", mem[21], 32'd0);
        check("cols0_writes", nwr, 2);

        w0 = wr_cnt;
        run_job(4'd2, 4'd3, 5'd0, 5'd9, 5'd30, 1'b0, 9, 1'b0, "nonsq", nwr);
        check("nonsq_y0", mem[30], 32'd71);
        check("nonsq_y1", mem[31], 32'd83);
        check("nonsq_waddr0", {27'd0, wr_log[w0 % 64]}, 32'd30);
        check("nonsq_waddr1", {27'd0, wr_log[(w0 + 1) % 64]}, 32'd31);
        check("nonsq_writes", nwr, 2);

        poke_mem(5'd22, 32'd77);
        @(negedge clk);
        rows = 4'd3; cols = 4'd3; a_base = 5'd0; x_base = 5'd9; y_base = 5'd22;
        accumulate = 1'b0; start = 1'b1;
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_wen", {31'd0, ram_wen_0}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_writes", wr_cnt - w0, 0);
        check("midrst_y_kept", mem[22], 32'd77);
        check("midrst_idle", {31'd0, busy}, 32'd0);

        poke_mem(5'd16, 32'hFFFF_FFFF);
        poke_mem(5'd17, 32'd2);
        poke_mem(5'd18, 32'd5);
        run_job(4'd1, 4'd1, 5'd16, 5'd17, 5'd18, 1'b0, 3, 1'b0, "ovf", nwr);
        check("ovf_y", mem[18], 32'hFFFF_FFFE);
        check("ovf_writes", nwr, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
